// File: rtl/vga_line_scheduler_pkg.sv
// Shared 640x480 VGA timing constants, NES line geometry and the scheduler state type.
package vga_line_scheduler_pkg;

    localparam int VGA_COORD_BITWIDTH = 11;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int NES_VISIBLE_LINES = 240;
    localparam int VGA_LINE_REPEAT   = VGA_V_VISIBLE / NES_VISIBLE_LINES;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        RUN        = 1'b1
    } sched_state_e;

    // Width of a counter that counts 0..repeat_count-1, never narrower than one bit.
    function automatic int rep_width(input int repeat_count);
        return (repeat_count > 1) ? $clog2(repeat_count) : 1;
    endfunction

endpackage

// File: rtl/vga_line_scheduler_if.sv
// Line-buffer handshake plus VGA timing outputs of the line scheduler.
interface vga_line_scheduler_if #(
    parameter int COORD_BITWIDTH = 11
);
    logic [1:0]                lines_available;
    logic                      line_advance;
    logic [COORD_BITWIDTH-1:0] vga_x;
    logic [COORD_BITWIDTH-1:0] vga_y;
    logic                      visible;
    logic                      hsync;
    logic                      vsync;
    logic [7:0]                nes_line;
    logic                      frame_start;
    logic                      underrun;
    logic                      running;

    modport master (
        input  lines_available,
        output line_advance, vga_x, vga_y, visible, hsync, vsync,
               nes_line, frame_start, underrun, running
    );

    modport slave (
        output lines_available,
        input  line_advance, vga_x, vga_y, visible, hsync, vsync,
               nes_line, frame_start, underrun, running
    );
endinterface

// File: rtl/vga_line_scheduler_timing_counter.sv
// VGA x/y raster counters with registered syncs and visible flag derived from next-state counters.
module vga_timing_counter
    import vga_line_scheduler_pkg::*;
#(
    parameter int COORD_BITWIDTH = VGA_COORD_BITWIDTH,
    parameter int H_VISIBLE      = VGA_H_VISIBLE,
    parameter int H_FRONT        = VGA_H_FRONT,
    parameter int H_SYNC         = VGA_H_SYNC,
    parameter int H_BACK         = VGA_H_BACK,
    parameter int V_VISIBLE      = VGA_V_VISIBLE,
    parameter int V_FRONT        = VGA_V_FRONT,
    parameter int V_SYNC         = VGA_V_SYNC,
    parameter int V_BACK         = VGA_V_BACK
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      en_i,
    input  logic                      run_i,
    output logic [COORD_BITWIDTH-1:0] x_o,
    output logic [COORD_BITWIDTH-1:0] y_o,
    output logic [COORD_BITWIDTH-1:0] x_next_o,
    output logic [COORD_BITWIDTH-1:0] y_next_o,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      visible_o
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_BITWIDTH-1:0] X_LAST   = COORD_BITWIDTH'(H_TOTAL - 1);
    localparam logic [COORD_BITWIDTH-1:0] Y_LAST   = COORD_BITWIDTH'(V_TOTAL - 1);
    localparam logic [COORD_BITWIDTH-1:0] X_VIS    = COORD_BITWIDTH'(H_VISIBLE);
    localparam logic [COORD_BITWIDTH-1:0] Y_VIS    = COORD_BITWIDTH'(V_VISIBLE);
    localparam logic [COORD_BITWIDTH-1:0] HS_START = COORD_BITWIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_BITWIDTH-1:0] HS_END   = COORD_BITWIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_BITWIDTH-1:0] VS_START = COORD_BITWIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_BITWIDTH-1:0] VS_END   = COORD_BITWIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COORD_BITWIDTH-1:0] x_q, x_d;
    logic [COORD_BITWIDTH-1:0] y_q, y_d;
    logic                      hsync_q, hsync_d;
    logic                      vsync_q, vsync_d;
    logic                      visible_q, visible_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // Decoding the next-state counters keeps syncs aligned with the registered x/y.
        hsync_d   = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d   = !((y_d >= VS_START) && (y_d < VS_END));
        visible_d = run_i && (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            visible_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            visible_q <= visible_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign x_next_o  = x_d;
    assign y_next_o  = y_d;
    assign hsync_o   = hsync_q;
    assign vsync_o   = vsync_q;
    assign visible_o = visible_q;

endmodule

// File: rtl/vga_line_scheduler.sv
// Paces NES line-buffer reads against VGA raster timing: waits for the first line, repeats each
// NES line LINE_REPEAT times, then releases it with a one-cycle advance pulse.
module vga_line_scheduler
    import vga_line_scheduler_pkg::*;
#(
    parameter int COORD_BITWIDTH = VGA_COORD_BITWIDTH,
    parameter int H_VISIBLE      = VGA_H_VISIBLE,
    parameter int H_FRONT        = VGA_H_FRONT,
    parameter int H_SYNC         = VGA_H_SYNC,
    parameter int H_BACK         = VGA_H_BACK,
    parameter int V_VISIBLE      = VGA_V_VISIBLE,
    parameter int V_FRONT        = VGA_V_FRONT,
    parameter int V_SYNC         = VGA_V_SYNC,
    parameter int V_BACK         = VGA_V_BACK,
    parameter int LINE_REPEAT    = VGA_LINE_REPEAT
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    vga_line_scheduler_if.master bus
);
    localparam int REP_W     = rep_width(LINE_REPEAT);
    localparam int NES_LINES = V_VISIBLE / LINE_REPEAT;

    localparam logic [REP_W-1:0]          REP_LAST = REP_W'(LINE_REPEAT - 1);
    localparam logic [7:0]                NES_LAST = 8'(NES_LINES - 1);
    localparam logic [COORD_BITWIDTH-1:0] X_DECIDE = COORD_BITWIDTH'(H_VISIBLE);
    localparam logic [COORD_BITWIDTH-1:0] Y_VIS    = COORD_BITWIDTH'(V_VISIBLE);

    sched_state_e              state_q, state_d;
    logic [REP_W-1:0]          rep_q, rep_d;
    logic [7:0]                nes_q, nes_d;
    logic                      adv_q, adv_d;
    logic                      und_q, und_d;
    logic                      fs_q, fs_d;
    logic                      count_en;
    logic                      run_next;
    logic [COORD_BITWIDTH-1:0] x_cur, y_cur, x_next, y_next;
    logic                      hsync, vsync, visible;

    // Counters only move once RUN is registered, so the first RUN cycle shows x=0,y=0.
    assign count_en = (state_q == RUN);
    assign run_next = (state_d == RUN);

    vga_timing_counter #(
        .COORD_BITWIDTH(COORD_BITWIDTH),
        .H_VISIBLE     (H_VISIBLE),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_VISIBLE     (V_VISIBLE),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK)
    ) u_timing (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .en_i     (count_en),
        .run_i    (run_next),
        .x_o      (x_cur),
        .y_o      (y_cur),
        .x_next_o (x_next),
        .y_next_o (y_next),
        .hsync_o  (hsync),
        .vsync_o  (vsync),
        .visible_o(visible)
    );

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        nes_d   = nes_q;
        adv_d   = 1'b0;
        und_d   = 1'b0;
        fs_d    = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (bus.lines_available != 2'd0) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                if ((x_next == '0) && (y_next == '0)) begin
                    rep_d = '0;
                    nes_d = '0;
                    fs_d  = 1'b1;
                end
                // One decision per visible line; an underrun keeps rep_q so the next line retries.
                if ((x_next == X_DECIDE) && (y_next < Y_VIS)) begin
                    if (rep_q < REP_LAST) begin
                        rep_d = rep_q + 1'b1;
                    end else if (bus.lines_available != 2'd0) begin
                        adv_d = 1'b1;
                        rep_d = '0;
                        if (nes_q < NES_LAST) nes_d = nes_q + 1'b1;
                    end else begin
                        und_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= WAIT_FIRST;
            rep_q   <= '0;
            nes_q   <= '0;
            adv_q   <= 1'b0;
            und_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            nes_q   <= nes_d;
            adv_q   <= adv_d;
            und_q   <= und_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.line_advance = adv_q;
    assign bus.vga_x        = x_cur;
    assign bus.vga_y        = y_cur;
    assign bus.visible      = visible;
    assign bus.hsync        = hsync;
    assign bus.vsync        = vsync;
    assign bus.nes_line     = nes_q;
    assign bus.frame_start  = fs_q;
    assign bus.underrun     = und_q;
    assign bus.running      = (state_q == RUN);

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Bench for vga_line_scheduler using a reduced raster so several full frames fit in a short run.
module tb_vga_line_scheduler;
    localparam int CW   = 11;
    localparam int HV   = 80;
    localparam int HF   = 8;
    localparam int HS   = 12;
    localparam int HB   = 10;
    localparam int VV   = 24;
    localparam int VF   = 3;
    localparam int VS   = 2;
    localparam int VB   = 4;
    localparam int LR   = 2;
    localparam int HT   = HV + HF + HS + HB;
    localparam int VT   = VV + VF + VS + VB;
    localparam int NESL = VV / LR;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int start_cyc = 0;

    // Reference state: cycles since entering RUN, plus per-NES-line bookkeeping.
    bit m_run = 1'b0;
    int m_t   = 0;
    int m_rep = 0;
    int m_nes = 0;
    bit e_adv = 1'b0;
    bit e_und = 1'b0;

    always #5 clk = ~clk;

    vga_line_scheduler_if #(.COORD_BITWIDTH(CW)) bus ();

    vga_line_scheduler #(
        .COORD_BITWIDTH(CW),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LINE_REPEAT(LR)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    function automatic int mx();
        return m_run ? (m_t % HT) : 0;
    endfunction

    function automatic int my();
        return m_run ? ((m_t / HT) % VT) : 0;
    endfunction

    function automatic logic [36:0] exp_vec();
        int   x;
        int   y;
        logic hs, vs, vis, fs;
        x   = mx();
        y   = my();
        hs  = !(x >= HV + HF && x < HV + HF + HS);
        vs  = !(y >= VV + VF && y < VV + VF + VS);
        vis = m_run && (x < HV) && (y < VV);
        fs  = m_run && (x == 0) && (y == 0);
        return {CW'(x), CW'(y), hs, vs, vis, e_adv, 8'(m_nes), fs, e_und, m_run};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {bus.vga_x, bus.vga_y, bus.hsync, bus.vsync, bus.visible, bus.line_advance,
                bus.nes_line, bus.frame_start, bus.underrun, bus.running};
    endfunction

    task automatic model_edge(input int la);
        int x;
        int y;
        e_adv = 1'b0;
        e_und = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_rep = 0; m_nes = 0;
        end else if (!m_run) begin
            if (la > 0) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else begin
            m_t++;
            x = m_t % HT;
            y = (m_t / HT) % VT;
            if (x == 0 && y == 0) begin
                m_rep = 0;
                m_nes = 0;
            end
            if (x == HV && y < VV) begin
                if (m_rep < LR - 1) m_rep++;
                else if (la > 0) begin
                    e_adv = 1'b1;
                    m_rep = 0;
                    if (m_nes < NESL - 1) m_nes++;
                end else e_und = 1'b1;
            end
        end
    endtask

    task automatic step();
        int la;
        la = int'(bus.lines_available);
        @(posedge clk);
        model_edge(la);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst_n = 1'b0;
        bus.lines_available = 2'd0;
        repeat (3) step();
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.line_advance || bus.frame_start || bus.underrun) pulses++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL wait_first cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pulses != 0 || bus.running !== 1'b0)
            $display("FAIL wait_idle pulses=%0d running=%b want 0/0", pulses, bus.running);
        else passed++;
    endtask

    task automatic test_start();
        int hs_low;
        int hs_first;
        hs_low   = 0;
        hs_first = -1;
        bus.lines_available = 2'd1;
        step();
        start_cyc = cyc;
        checks++;
        if ({bus.running, bus.frame_start, bus.vga_x, bus.vga_y} !== {1'b1, 1'b1, CW'(0), CW'(0)})
            $display("FAIL start got run=%b fs=%b x=%0d y=%0d want 1 1 0 0",
                     bus.running, bus.frame_start, bus.vga_x, bus.vga_y);
        else passed++;
        for (int i = 0; i < HT - 1; i++) begin
            step();
            if (!bus.hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(bus.vga_x);
            end
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL first_line cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (hs_low != HS || hs_first != HV + HF)
            $display("FAIL hsync_window got len=%0d start=%0d want len=%0d start=%0d",
                     hs_low, hs_first, HS, HV + HF);
        else passed++;
    endtask

    task automatic test_full_frame();
        int adv, und, bad_adv, max_nes, vs_low, vs_first, vs_last;
        bit seen;
        adv = 0; und = 0; bad_adv = 0; max_nes = 0; vs_low = 0; vs_first = -1; vs_last = -1;
        seen = 1'b0;
        bus.lines_available = 2'd2;
        for (int i = 0; i < HT * VT + 10 && !seen; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL full_frame cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
            if (bus.line_advance) begin
                adv++;
                if (int'(bus.vga_x) != HV || int'(bus.vga_y) % 2 != 1) bad_adv++;
            end
            if (bus.underrun) und++;
            if (int'(bus.nes_line) > max_nes) max_nes = int'(bus.nes_line);
            if (!bus.vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(bus.vga_y);
                vs_last = int'(bus.vga_y);
            end
            if (bus.frame_start) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc - start_cyc != HT * VT)
            $display("FAIL frame_period got seen=%0d period=%0d want 1 %0d", seen, cyc - start_cyc, HT * VT);
        else passed++;
        checks++;
        if (adv != NESL || bad_adv != 0 || und != 0)
            $display("FAIL advances got adv=%0d misplaced=%0d und=%0d want %0d 0 0", adv, bad_adv, und, NESL);
        else passed++;
        checks++;
        if (max_nes != NESL - 1) $display("FAIL nes_saturate got=%0d want=%0d", max_nes, NESL - 1);
        else passed++;
        checks++;
        if (vs_low != VS * HT || vs_first != VV + VF || vs_last != VV + VF + VS - 1)
            $display("FAIL vsync_window got len=%0d rows=%0d..%0d want %0d %0d..%0d",
                     vs_low, vs_first, vs_last, VS * HT, VV + VF, VV + VF + VS - 1);
        else passed++;
    endtask

    task automatic test_underrun();
        int n;
        bus.lines_available = 2'd2;
        n = 0;
        while (int'(bus.vga_y) != 5 && n < 6 * HT) begin
            step();
            n++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL underrun_lead cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        bus.lines_available = 2'd0;
        n = 0;
        while (int'(bus.vga_x) != HV && n < HT) begin
            step();
            n++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL underrun_line cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if ({bus.underrun, bus.line_advance, bus.nes_line, bus.vga_y} !== {1'b1, 1'b0, 8'd2, CW'(5)})
            $display("FAIL underrun_pulse got und=%b adv=%b nes=%0d y=%0d want 1 0 2 5",
                     bus.underrun, bus.line_advance, bus.nes_line, bus.vga_y);
        else passed++;
        bus.lines_available = 2'd1;
        n = 0;
        while (!(int'(bus.vga_y) == 6 && int'(bus.vga_x) == HV) && n < 2 * HT) begin
            step();
            n++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL underrun_retry cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if ({bus.line_advance, bus.underrun, bus.nes_line} !== {1'b1, 1'b0, 8'd3})
            $display("FAIL retry_advance got adv=%b und=%b nes=%0d want 1 0 3",
                     bus.line_advance, bus.underrun, bus.nes_line);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int n;
        bus.lines_available = 2'd1;
        n = 0;
        while (!(int'(bus.vga_x) == 37 && int'(bus.vga_y) == 10) && n < HT * VT) begin
            step();
            n++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL midframe_lead cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        #2 rst_n = 1'b0;
        #1;
        m_run = 1'b0; m_t = 0; m_rep = 0; m_nes = 0; e_adv = 1'b0; e_und = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL async_reset got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        repeat (3) step();
        rst_n = 1'b1;
        bus.lines_available = 2'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL rewait cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else passed++;
        end
        bus.lines_available = 2'd1;
        step();
        checks++;
        if ({bus.running, bus.frame_start, bus.vga_x, bus.vga_y} !== {1'b1, 1'b1, CW'(0), CW'(0)})
            $display("FAIL restart got run=%b fs=%b x=%0d y=%0d want 1 1 0 0",
                     bus.running, bus.frame_start, bus.vga_x, bus.vga_y);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * HT * VT; i++) begin
            if ($urandom_range(0, 39) == 0) bus.lines_available = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random cyc=%0d la=%0d got=%h exp=%h", cyc, bus.lines_available,
                         dut_vec(), exp_vec());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_frame();
        test_underrun();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
